aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_key_expand.sv | 157 +++++++++++++++
 tb/tb_aes_key_expand.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: loads a cipher key and streams round keys 0..NUM_ROUNDS with a valid/ready handshake.
// Define AES_KEY_ZEROIZE_EN to clear round_key when the last round key is accepted.
module aes_key_expand #(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid_in,
  input  logic [DATA_W-1:0] key_in,
  input  logic              ready_in,
  output logic              key_ready_out,
  output logic              key_valid_out,
  output logic [DATA_W-1:0] round_key,
  output logic [3:0]        round_idx,
  output logic              last_out
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

`ifdef AES_KEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  // FIPS 197 S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = {8'd255 - b, 3'd7};
    return SBOX[pos -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // i is the index of the round key being produced.
  function automatic logic [DATA_W-1:0] next_key(input logic [DATA_W-1:0] k,
                                                 input logic [3:0]        i);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(i), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t            state_q, state_d;
  logic              load, advance, finish;
  logic [DATA_W-1:0] rk_p0;
  logic [3:0]        idx_p0;
  logic [3:0]        idx_nx;

  assign idx_nx = idx_p0 + 4'd1;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid_in) begin
          load    = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (ready_in) begin
          if (idx_p0 == LAST_IDX) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-key register: load, advance one round, or clear on the last accept when zeroizing.
  always_ff @(posedge clk) begin
    if (reset) begin
      rk_p0  <= '0;
      idx_p0 <= 4'd0;
    end else if (load) begin
      rk_p0  <= key_in;
      idx_p0 <= 4'd0;
    end else if (advance) begin
      rk_p0  <= next_key(rk_p0, idx_nx);
      idx_p0 <= idx_nx;
    end else if (finish && ZEROIZE) begin
      rk_p0  <= '0;
    end
  end

  assign key_ready_out = (state_q == IDLE);
  assign key_valid_out = (state_q == EMIT);
  assign round_key     = rk_p0;
  assign round_idx     = idx_p0;
  assign last_out      = (state_q == EMIT) && (idx_p0 == LAST_IDX);

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: expected round keys are queued at load time, a monitor pops them on each handshake.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid_in;
  logic [127:0] key_in;
  logic         ready_in;
  logic         key_ready_out;
  logic         key_valid_out;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         last_out;

  aes_key_expand #(.DATA_W(128), .NUM_ROUNDS(10)) dut (
    .clk(clk), .reset(reset), .key_valid_in(key_valid_in), .key_in(key_in),
    .ready_in(ready_in), .key_ready_out(key_ready_out), .key_valid_out(key_valid_out),
    .round_key(round_key), .round_idx(round_idx), .last_out(last_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    bit           chk;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           hs_count = 0;
  logic [127:0] std_keys [0:10];
  logic [127:0] zero_r1, zero_r10;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake pops the front entry; a stall compares against it without popping.
  always @(negedge clk) begin
    exp_t e;
    if (key_valid_out) begin
      if (ready_in) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got idx %0d key %h, expected none", round_idx, round_key);
        end else begin
          e = exp_q.pop_front();
          hs_count++;
          if (e.chk) chk("round_key", round_key, e.key);
          chk("round_idx", 128'(round_idx), 128'(e.idx));
          chk("last_out", 128'(last_out), 128'(e.idx == 4'd10));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q[0];
        if (e.chk) chk("stall_key", round_key, e.key);
        chk("stall_idx", 128'(round_idx), 128'(e.idx));
      end
    end else begin
      chk("last_when_idle", 128'(last_out), 128'(0));
    end
  end

  task automatic push_std(input int upto);
    for (int i = 0; i <= upto; i++) exp_q.push_back('{key: std_keys[i], idx: 4'(i), chk: 1'b1});
  endtask

  task automatic push_zero();
    for (int i = 0; i <= 10; i++) begin
      exp_t e;
      e.idx = 4'(i);
      e.chk = (i == 0) || (i == 1) || (i == 10);
      e.key = (i == 1) ? zero_r1 : (i == 10) ? zero_r10 : '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [127:0] k);
    int n;
    n = 0;
    while (!key_ready_out && n < 100) begin
      cycles(1);
      n++;
    end
    chk("load_wait_timeout", 128'(key_ready_out), 128'(1));
    key_valid_in = 1'b1;
    key_in       = k;
    cycles(1);
    key_valid_in = 1'b0;
  endtask

  task automatic drain(input bit random_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !key_ready_out) && n < 400) begin
      if (random_ready) ready_in = 1'($urandom_range(0, 1));
      cycles(1);
      n++;
    end
    ready_in = 1'b1;
    chk("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int hs0;
    std_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    std_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    std_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    std_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    std_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    std_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    std_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    std_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    std_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    std_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    std_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_r1      = 128'h62636363626363636263636362636363;
    zero_r10     = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    reset        = 1'b1;
    key_valid_in = 1'b1;
    key_in       = 128'hffffffffffffffffffffffffffffffff;
    ready_in     = 1'b1;
    cycles(2);
    chk("reset_ready", 128'(key_ready_out), 128'(1));
    chk("reset_valid", 128'(key_valid_out), 128'(0));
    chk("reset_key", round_key, 128'h0);
    chk("reset_idx", 128'(round_idx), 128'(0));
    chk("reset_last", 128'(last_out), 128'(0));
    key_valid_in = 1'b0;
    reset        = 1'b0;
    cycles(1);

    // Straight run with ready held high.
    push_std(10);
    load(std_keys[0]);
    chk("latency_r0", round_key, std_keys[0]);
    chk("ready_low_in_emit", 128'(key_ready_out), 128'(0));
    cycles(10);
    chk("r10_idx", 128'(round_idx), 128'(10));
    chk("r10_last", 128'(last_out), 128'(1));
    cycles(1);
    chk("idle_ready_t12", 128'(key_ready_out), 128'(1));
    chk("idle_valid_t12", 128'(key_valid_out), 128'(0));
`ifdef AES_KEY_ZEROIZE_EN
    chk("key_after_last", round_key, 128'h0);
`else
    chk("key_after_last", round_key, std_keys[10]);
`endif
    drain(1'b0);

    // Random backpressure.
    hs0 = hs_count;
    push_std(10);
    load(std_keys[0]);
    drain(1'b1);
    chk("handshakes_random", 128'(hs_count - hs0), 128'(11));

    // New key offered mid-expansion must be ignored.
    push_std(10);
    load(std_keys[0]);
    cycles(4);
    chk("pulse_at_idx4", 128'(round_idx), 128'(4));
    key_valid_in = 1'b1;
    key_in       = 128'h000102030405060708090a0b0c0d0e0f;
    cycles(1);
    key_valid_in = 1'b0;
    chk("ready_after_pulse", 128'(key_ready_out), 128'(0));
    cycles(5);
    chk("ready_at_r10", 128'(key_ready_out), 128'(0));
    drain(1'b0);

    // Reset while round 6 is presented.
    push_std(5);
    load(std_keys[0]);
    cycles(6);
    chk("abort_at_idx6", 128'(round_idx), 128'(6));
    ready_in = 1'b0;
    reset    = 1'b1;
    cycles(1);
    chk("abort_valid", 128'(key_valid_out), 128'(0));
    chk("abort_key", round_key, 128'h0);
    chk("abort_ready", 128'(key_ready_out), 128'(1));
    reset    = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("no_emit_after_abort", 128'(key_valid_out), 128'(0));
    end
    chk("abort_queue_empty", 128'(exp_q.size()), 128'(0));

    // Fresh load with the all-zero key restarts at round 0.
    push_zero();
    load(128'h0);
    chk("restart_idx0", 128'(round_idx), 128'(0));
    drain(1'b0);
`ifdef AES_KEY_ZEROIZE_EN
    chk("zero_key_after_last", round_key, 128'h0);
`else
    chk("zero_key_after_last", round_key, zero_r10);
`endif

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
